// File: rtl/sdrc_sram_resp.sv
// rtl/sdrc_sram_resp.sv - SRAM-backed responder for the SDRAM controller request interface
// Services sdr_req commands from a local word memory and emulates refresh stalls.
module sdrc_sram_resp #(
    parameter int dw         = 32,
    parameter int bl         = 9,
    parameter int APP_AW     = 26,
    parameter int MEM_AW     = 10,
    parameter int RD_LAT     = 2,
    parameter int REF_PERIOD = 512,
    parameter int REF_CYCLES = 4
) (
    input  logic              sdram_clk,
    input  logic              sdram_resetn,
    input  logic              sdr_req,
    input  logic [APP_AW-1:0] sdr_req_addr,
    input  logic [bl-1:0]     sdr_req_len,
    input  logic              sdr_req_wr_n,
    output logic              sdr_req_ack,
    output logic              sdr_busy_n,
    output logic              sdr_wr_next,
    input  logic [dw-1:0]     sdr_wr_data,
    input  logic [dw/8-1:0]   sdr_wr_en_n,
    output logic              sdr_rd_valid,
    output logic              sdr_last_rd,
    output logic [dw-1:0]     sdr_rd_data
);
    localparam int NB  = dw / 8;
    localparam int CW  = 16;
    localparam int RCW = (REF_PERIOD > 1) ? $clog2(REF_PERIOD) : 1;

    typedef enum logic [2:0] {
        S_IDLE, S_ACK, S_WRITE, S_RDLAT, S_READ, S_REFRESH
    } state_t;

    state_t              state_q, state_d;
    logic [MEM_AW-1:0]   addr_q, addr_d;
    logic [bl-1:0]       rem_q, rem_d;
    logic [CW-1:0]       cnt_q, cnt_d;
    logic [RCW-1:0]      ref_cnt_q, ref_cnt_d;
    logic                ref_due_q, ref_due_d;
    logic                ref_set;
    logic [bl-1:0]       n_eff;
    logic                ack_q, ack_d;
    logic                busy_n_q, busy_n_d;
    logic                wr_next_q, wr_next_d;
    logic                rd_valid_q, rd_valid_d;
    logic                last_rd_q, last_rd_d;
    logic [dw-1:0]       rd_data_q, rd_data_d;

    logic [dw-1:0]       mem [0:(2**MEM_AW)-1];

    logic                unused_addr_bits;
    assign unused_addr_bits = ^sdr_req_addr[APP_AW-1:MEM_AW];

    assign n_eff = (sdr_req_len == '0) ? bl'(1) : sdr_req_len;

    always_comb begin
        state_d   = state_q;
        addr_d    = addr_q;
        rem_d     = rem_q;
        cnt_d     = cnt_q;
        ref_cnt_d = ref_cnt_q;
        ref_set   = 1'b0;
        if (REF_PERIOD != 0) begin
            if (ref_cnt_q == RCW'(REF_PERIOD - 1)) begin
                ref_cnt_d = '0;
                ref_set   = 1'b1;
            end else begin
                ref_cnt_d = ref_cnt_q + RCW'(1);
            end
        end

        // rem counts beats still to be issued after the current one
        case (state_q)
            S_IDLE: begin
                if (ref_due_q) begin
                    state_d = S_REFRESH;
                    cnt_d   = CW'(REF_CYCLES - 1);
                end else if (sdr_req) begin
                    state_d = S_ACK;
                end
            end
            S_ACK: begin
                addr_d = sdr_req_addr[MEM_AW-1:0];
                if (!sdr_req_wr_n) begin
                    state_d = S_WRITE;
                    rem_d   = n_eff - bl'(1);
                end else begin
                    state_d = S_RDLAT;
                    rem_d   = n_eff;
                    cnt_d   = CW'(RD_LAT - 1);
                end
            end
            S_WRITE: begin
                addr_d = addr_q + MEM_AW'(1);
                if (rem_q == '0) state_d = S_IDLE;
                else             rem_d   = rem_q - bl'(1);
            end
            S_RDLAT: begin
                if (cnt_q == '0) begin
                    state_d = S_READ;
                    rem_d   = rem_q - bl'(1);
                end else begin
                    cnt_d = cnt_q - CW'(1);
                end
            end
            S_READ: begin
                if (rem_q == '0) state_d = S_IDLE;
                else             rem_d   = rem_q - bl'(1);
            end
            S_REFRESH: begin
                if (cnt_q == '0) state_d = S_IDLE;
                else             cnt_d   = cnt_q - CW'(1);
            end
            default: state_d = S_IDLE;
        endcase

        // Each read beat is fetched on the edge that opens it.
        rd_data_d = rd_data_q;
        if (state_d == S_READ) begin
            rd_data_d = mem[addr_q];
            addr_d    = addr_q + MEM_AW'(1);
        end

        if (ref_set)
            ref_due_d = 1'b1;
        else if (state_q == S_IDLE && state_d == S_REFRESH)
            ref_due_d = 1'b0;
        else
            ref_due_d = ref_due_q;

        ack_d      = (state_d == S_ACK);
        busy_n_d   = (state_d == S_IDLE);
        wr_next_d  = (state_d == S_WRITE);
        rd_valid_d = (state_d == S_READ);
        last_rd_d  = (state_d == S_READ) && (rem_d == '0);
    end

    always_ff @(posedge sdram_clk or negedge sdram_resetn) begin
        if (!sdram_resetn) begin
            state_q    <= S_IDLE;
            addr_q     <= '0;
            rem_q      <= '0;
            cnt_q      <= '0;
            ref_cnt_q  <= '0;
            ref_due_q  <= 1'b0;
            ack_q      <= 1'b0;
            busy_n_q   <= 1'b1;
            wr_next_q  <= 1'b0;
            rd_valid_q <= 1'b0;
            last_rd_q  <= 1'b0;
            rd_data_q  <= '0;
        end else begin
            state_q    <= state_d;
            addr_q     <= addr_d;
            rem_q      <= rem_d;
            cnt_q      <= cnt_d;
            ref_cnt_q  <= ref_cnt_d;
            ref_due_q  <= ref_due_d;
            ack_q      <= ack_d;
            busy_n_q   <= busy_n_d;
            wr_next_q  <= wr_next_d;
            rd_valid_q <= rd_valid_d;
            last_rd_q  <= last_rd_d;
            rd_data_q  <= rd_data_d;
        end
    end

    // Write data is the upstream FIFO head, consumed on the edge closing a wr_next cycle.
    always_ff @(posedge sdram_clk) begin
        if (state_q == S_WRITE) begin
            for (int i = 0; i < NB; i++) begin
                if (!sdr_wr_en_n[i])
                    mem[addr_q][8*i +: 8] <= sdr_wr_data[8*i +: 8];
            end
        end
    end

    assign sdr_req_ack  = ack_q;
    assign sdr_busy_n   = busy_n_q;
    assign sdr_wr_next  = wr_next_q;
    assign sdr_rd_valid = rd_valid_q;
    assign sdr_last_rd  = last_rd_q;
    assign sdr_rd_data  = rd_data_q;
endmodule

// File: tb/tb_sdrc_sram_resp.sv
// tb/tb_sdrc_sram_resp.sv - directed self-checking bench for sdrc_sram_resp
module tb_sdrc_sram_resp;
    localparam int DW = 32, BL = 9, APP_AW = 26, MEM_AW = 10;
    localparam int RD_LAT = 2, REF_PERIOD = 16, REF_CYCLES = 4;

    logic              sdram_clk = 1'b0;
    logic              sdram_resetn = 1'b0;
    logic              sdr_req = 1'b0;
    logic [APP_AW-1:0] sdr_req_addr = '0;
    logic [BL-1:0]     sdr_req_len = '0;
    logic              sdr_req_wr_n = 1'b1;
    logic              sdr_req_ack;
    logic              sdr_busy_n;
    logic              sdr_wr_next;
    logic [DW-1:0]     sdr_wr_data = '0;
    logic [DW/8-1:0]   sdr_wr_en_n = '1;
    logic              sdr_rd_valid;
    logic              sdr_last_rd;
    logic [DW-1:0]     sdr_rd_data;

    int n_checks = 0;
    int n_fail = 0;
    int cyc;
    logic [31:0] wq[$];
    logic [31:0] rq[$];

    sdrc_sram_resp #(
        .dw(DW), .bl(BL), .APP_AW(APP_AW), .MEM_AW(MEM_AW),
        .RD_LAT(RD_LAT), .REF_PERIOD(REF_PERIOD), .REF_CYCLES(REF_CYCLES)
    ) dut (
        .sdram_clk(sdram_clk), .sdram_resetn(sdram_resetn),
        .sdr_req(sdr_req), .sdr_req_addr(sdr_req_addr), .sdr_req_len(sdr_req_len),
        .sdr_req_wr_n(sdr_req_wr_n), .sdr_req_ack(sdr_req_ack), .sdr_busy_n(sdr_busy_n),
        .sdr_wr_next(sdr_wr_next), .sdr_wr_data(sdr_wr_data), .sdr_wr_en_n(sdr_wr_en_n),
        .sdr_rd_valid(sdr_rd_valid), .sdr_last_rd(sdr_last_rd), .sdr_rd_data(sdr_rd_data)
    );

    always #5 sdram_clk = ~sdram_clk;

    // Cycles since reset release; refresh becomes due when this reaches a multiple of REF_PERIOD.
    always @(posedge sdram_clk or negedge sdram_resetn)
        if (!sdram_resetn) cyc <= 0;
        else               cyc <= cyc + 1;

    initial begin
        #400000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic step;
        @(posedge sdram_clk);
        #1;
    endtask

    task automatic wait_ack(input string tag);
        bit ok = 1'b0;
        for (int i = 0; i < 60; i++) begin
            step();
            if (sdr_req_ack) begin
                ok = 1'b1;
                break;
            end
        end
        check({tag, "_ack"}, 32'(ok), 32'd1);
        sdr_req = 1'b0;
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_ack"},   32'(sdr_req_ack),  32'd0);
        check({tag, "_busy"},  32'(sdr_busy_n),   32'd1);
        check({tag, "_wrnx"},  32'(sdr_wr_next),  32'd0);
        check({tag, "_valid"}, 32'(sdr_rd_valid), 32'd0);
        check({tag, "_last"},  32'(sdr_last_rd),  32'd0);
        check({tag, "_data"},  sdr_rd_data,       32'd0);
    endtask

    task automatic do_write(input string tag, input logic [APP_AW-1:0] addr,
                            input logic [BL-1:0] len, input logic [3:0] en_n);
        int n;
        n = (len == 0) ? 1 : int'(len);
        sdr_req_addr = addr;
        sdr_req_len  = len;
        sdr_req_wr_n = 1'b0;
        sdr_req      = 1'b1;
        wait_ack(tag);
        for (int b = 0; b < n; b++) begin
            step();
            check({tag, "_wr_next"}, 32'(sdr_wr_next), 32'd1);
            if (b == 0) check({tag, "_ack_pulse"}, 32'(sdr_req_ack), 32'd0);
            sdr_wr_data = wq[b];
            sdr_wr_en_n = en_n;
        end
        step();
        check({tag, "_wr_end"}, 32'(sdr_wr_next), 32'd0);
        check({tag, "_idle"},   32'(sdr_busy_n),  32'd1);
        sdr_wr_en_n = '1;
    endtask

    task automatic do_read(input string tag, input logic [APP_AW-1:0] addr,
                           input logic [BL-1:0] len);
        int n;
        n = (len == 0) ? 1 : int'(len);
        sdr_req_addr = addr;
        sdr_req_len  = len;
        sdr_req_wr_n = 1'b1;
        sdr_req      = 1'b1;
        wait_ack(tag);
        for (int l = 0; l < RD_LAT; l++) begin
            step();
            check({tag, "_lat_valid"}, 32'(sdr_rd_valid), 32'd0);
            if (l == 0) check({tag, "_ack_pulse"}, 32'(sdr_req_ack), 32'd0);
        end
        for (int b = 0; b < n; b++) begin
            step();
            check({tag, "_valid"}, 32'(sdr_rd_valid), 32'd1);
            check({tag, "_data"},  sdr_rd_data, rq[b]);
            check({tag, "_last"},  32'(sdr_last_rd), 32'(b == n - 1));
        end
        step();
        check({tag, "_end_valid"}, 32'(sdr_rd_valid), 32'd0);
        check({tag, "_idle"},      32'(sdr_busy_n),   32'd1);
    endtask

    initial begin
        repeat (3) step();
        check_reset_outputs("rst_init");
        sdram_resetn = 1'b1;
        repeat (5) step();
        sdram_resetn = 1'b0;
        #1;
        check_reset_outputs("rst_idle");
        step();
        sdram_resetn = 1'b1;
        step();

        wq = '{32'hDEADBEEF};
        do_write("wr1", 26'h010, 9'd1, 4'b0000);
        rq = '{32'hDEADBEEF};
        do_read("rd1", 26'h010, 9'd1);

        wq = '{32'h55555555};
        do_write("wr_pre21", 26'h021, 9'd1, 4'b0000);
        wq = '{32'hCAFEF00D, 32'h12345678};
        do_write("wr_len0", 26'h020, 9'd0, 4'b0000);
        rq = '{32'hCAFEF00D, 32'h55555555};
        do_read("rd_len0", 26'h020, 9'd2);

        wq = '{32'hAAAAAAAA};
        do_write("wr_preAA", 26'h030, 9'd1, 4'b0000);
        wq = '{32'h11223344};
        do_write("wr_mask", 26'h030, 9'd1, 4'b0101);
        rq = '{32'h11AA33AA};
        do_read("rd_mask", 26'h030, 9'd1);

        wq = '{32'd1, 32'd2, 32'd3, 32'd4};
        do_write("wr_wrap", 26'h3FE, 9'd4, 4'b0000);
        rq = '{32'd1, 32'd2, 32'd3, 32'd4};
        do_read("rd_wrap", 26'h3FE, 9'd4);
        rq = '{32'd3, 32'd4};
        do_read("rd_wrap0", 26'h000, 9'd2);
        rq = '{32'hDEADBEEF};
        do_read("rd_upper", 26'h0410, 9'd1);

        // Raise a request in exactly the cycle refresh becomes due.
        repeat (20) step();
        for (int i = 0; i < 20 && (cyc % REF_PERIOD) != REF_PERIOD - 1; i++) step();
        check("ref_pre_idle", 32'(sdr_busy_n), 32'd1);
        step();
        sdr_req_addr = 26'h010;
        sdr_req_len  = 9'd1;
        sdr_req_wr_n = 1'b1;
        sdr_req      = 1'b1;
        for (int k = 0; k < REF_CYCLES; k++) begin
            step();
            check("ref_busy", 32'(sdr_busy_n), 32'd0);
            check("ref_noack", 32'(sdr_req_ack), 32'd0);
        end
        step();
        check("ref_back_idle", 32'(sdr_busy_n), 32'd1);
        check("ref_idle_noack", 32'(sdr_req_ack), 32'd0);
        step();
        check("ref_ack", 32'(sdr_req_ack), 32'd1);
        sdr_req = 1'b0;
        repeat (RD_LAT) step();
        step();
        check("ref_rd_valid", 32'(sdr_rd_valid), 32'd1);
        check("ref_rd_data", sdr_rd_data, 32'hDEADBEEF);
        check("ref_rd_last", 32'(sdr_last_rd), 32'd1);
        step();

        wq = '{32'h100, 32'h101, 32'h102, 32'h103, 32'h104, 32'h105, 32'h106, 32'h107};
        do_write("wr_burst8", 26'h100, 9'd8, 4'b0000);
        sdr_req_addr = 26'h100;
        sdr_req_len  = 9'd8;
        sdr_req_wr_n = 1'b1;
        sdr_req      = 1'b1;
        wait_ack("rd_abort");
        repeat (RD_LAT) step();
        for (int b = 0; b < 3; b++) begin
            step();
            check("rd_abort_valid", 32'(sdr_rd_valid), 32'd1);
            check("rd_abort_data", sdr_rd_data, 32'h100 + 32'(b));
            check("rd_abort_last", 32'(sdr_last_rd), 32'd0);
        end
        sdram_resetn = 1'b0;
        #1;
        check_reset_outputs("rst_mid");
        for (int k = 0; k < 2; k++) begin
            step();
            check("rst_hold_valid", 32'(sdr_rd_valid), 32'd0);
            check("rst_hold_last", 32'(sdr_last_rd), 32'd0);
        end
        sdram_resetn = 1'b1;
        step();
        rq = '{32'h100};
        do_read("rd_after_rst", 26'h100, 9'd1);
        rq = '{32'h107};
        do_read("rd_after_rst7", 26'h107, 9'd1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
